// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I definitions for the decode stage and the ALU.
//   - XLEN_W          : datapath width (only 32 is supported)
//   - opcode / funct3 / funct7 encodings used by the decoder
//   - alu_op_t        : ALU operation selector (NOP encodes as zero)
//   - a_sel_t/b_sel_t : ALU operand source selects
//   - dec_t           : packed decoded command handed to execute
//   - imm_* helpers   : immediate extraction per instruction format
package riscv_pkg;

  localparam int XLEN_W = 32;

  // Major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // funct3 for OP / OP-IMM
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // funct3 for loads
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // funct3 for stores
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // funct3 for branches
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // funct7
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    A_RS1  = 2'd0,
    A_PC   = 2'd1,
    A_ZERO = 2'd2
  } a_sel_t;

  typedef enum logic {
    B_RS2 = 1'b0,
    B_IMM = 1'b1
  } b_sel_t;

  typedef struct packed {
    logic [XLEN_W-1:0] pc;
    logic [XLEN_W-1:0] imm;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    alu_op_t           alu_op;
    a_sel_t            a_sel;
    b_sel_t            b_sel;
    logic              b_neg;
    logic              shift;
    logic              rd_we;
    logic              mem_rd;
    logic              mem_wr;
    logic [2:0]        funct3;
    logic              branch;
    logic              jump;
    logic              illegal;
  } dec_t;

  function automatic logic [XLEN_W-1:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [XLEN_W-1:0] imm_s(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:25], instr[11:7]};
  endfunction

  function automatic logic [XLEN_W-1:0] imm_b(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [XLEN_W-1:0] imm_u(input logic [31:0] instr);
    return {instr[31:12], 12'b0};
  endfunction

  function automatic logic [XLEN_W-1:0] imm_j(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  // Shift amounts are zero-extended; execute masks b to 5 bits anyway.
  function automatic logic [XLEN_W-1:0] imm_shamt(input logic [31:0] instr);
    return {{(XLEN_W-5){1'b0}}, instr[24:20]};
  endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// rv32i_decoder: purely combinational RV32I instruction decoder.
//   instr_i : raw 32-bit instruction
//   pc_i    : address of the instruction, carried into the command
//   dec_o   : decoded command (riscv_pkg::dec_t)
// Register index fields are only populated when the format uses them, and
// funct3 is only carried for loads, stores and branches, so execute and
// hazard logic never see stale immediate bits as register numbers.
module rv32i_decoder
  import riscv_pkg::*;
(
  input  logic [XLEN_W-1:0] instr_i,
  input  logic [XLEN_W-1:0] pc_i,
  output dec_t              dec_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd_f;
  logic [4:0] rs1_f;
  logic [4:0] rs2_f;

  assign opcode = instr_i[6:0];
  assign rd_f   = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign rs1_f  = instr_i[19:15];
  assign rs2_f  = instr_i[24:20];
  assign funct7 = instr_i[31:25];

  dec_t dec_c;
  logic writes_rd;
  logic illegal;

  always_comb begin
    dec_c     = '0;
    dec_c.pc  = pc_i;
    writes_rd = 1'b0;
    illegal   = 1'b0;

    case (opcode)
      OPC_LUI: begin
        dec_c.rd     = rd_f;
        dec_c.imm    = imm_u(instr_i);
        dec_c.alu_op = ALU_ADD;
        dec_c.a_sel  = A_ZERO;
        dec_c.b_sel  = B_IMM;
        writes_rd    = 1'b1;
      end

      OPC_AUIPC: begin
        dec_c.rd     = rd_f;
        dec_c.imm    = imm_u(instr_i);
        dec_c.alu_op = ALU_ADD;
        dec_c.a_sel  = A_PC;
        dec_c.b_sel  = B_IMM;
        writes_rd    = 1'b1;
      end

      // ALU forms the jump target pc+imm; the link value is execute's job.
      OPC_JAL: begin
        dec_c.rd     = rd_f;
        dec_c.imm    = imm_j(instr_i);
        dec_c.alu_op = ALU_ADD;
        dec_c.a_sel  = A_PC;
        dec_c.b_sel  = B_IMM;
        dec_c.jump   = 1'b1;
        writes_rd    = 1'b1;
      end

      OPC_JALR: begin
        dec_c.rd     = rd_f;
        dec_c.rs1    = rs1_f;
        dec_c.imm    = imm_i(instr_i);
        dec_c.alu_op = ALU_ADD;
        dec_c.a_sel  = A_RS1;
        dec_c.b_sel  = B_IMM;
        dec_c.jump   = 1'b1;
        writes_rd    = 1'b1;
      end

      // Branch comparison happens in execute using funct3; ALU stays idle.
      OPC_BRANCH: begin
        dec_c.rs1    = rs1_f;
        dec_c.rs2    = rs2_f;
        dec_c.imm    = imm_b(instr_i);
        dec_c.alu_op = ALU_NOP;
        dec_c.a_sel  = A_RS1;
        dec_c.b_sel  = B_RS2;
        dec_c.funct3 = funct3;
        dec_c.branch = 1'b1;
        case (funct3)
          F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU: ;
          default: illegal = 1'b1;
        endcase
      end

      OPC_LOAD: begin
        dec_c.rd     = rd_f;
        dec_c.rs1    = rs1_f;
        dec_c.imm    = imm_i(instr_i);
        dec_c.alu_op = ALU_ADD;
        dec_c.a_sel  = A_RS1;
        dec_c.b_sel  = B_IMM;
        dec_c.funct3 = funct3;
        dec_c.mem_rd = 1'b1;
        writes_rd    = 1'b1;
        case (funct3)
          F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ;
          default: illegal = 1'b1;
        endcase
      end

      OPC_STORE: begin
        dec_c.rs1    = rs1_f;
        dec_c.rs2    = rs2_f;
        dec_c.imm    = imm_s(instr_i);
        dec_c.alu_op = ALU_ADD;
        dec_c.a_sel  = A_RS1;
        dec_c.b_sel  = B_IMM;
        dec_c.funct3 = funct3;
        dec_c.mem_wr = 1'b1;
        case (funct3)
          F3_SB, F3_SH, F3_SW: ;
          default: illegal = 1'b1;
        endcase
      end

      OPC_OP_IMM: begin
        dec_c.rd    = rd_f;
        dec_c.rs1   = rs1_f;
        dec_c.imm   = imm_i(instr_i);
        dec_c.a_sel = A_RS1;
        dec_c.b_sel = B_IMM;
        writes_rd   = 1'b1;
        case (funct3)
          F3_ADD:  dec_c.alu_op = ALU_ADD;
          F3_SLT:  dec_c.alu_op = ALU_SLT;
          F3_SLTU: dec_c.alu_op = ALU_SLTU;
          F3_XOR:  dec_c.alu_op = ALU_XOR;
          F3_OR:   dec_c.alu_op = ALU_OR;
          F3_AND:  dec_c.alu_op = ALU_AND;
          F3_SLL: begin
            dec_c.alu_op = ALU_SLL;
            dec_c.shift  = 1'b1;
            dec_c.imm    = imm_shamt(instr_i);
            illegal      = (funct7 != F7_BASE);
          end
          default: begin  // F3_SR
            dec_c.shift = 1'b1;
            dec_c.imm   = imm_shamt(instr_i);
            if (funct7 == F7_BASE)     dec_c.alu_op = ALU_SRL;
            else if (funct7 == F7_ALT) dec_c.alu_op = ALU_SRA;
            else                       illegal      = 1'b1;
          end
        endcase
      end

      OPC_OP: begin
        dec_c.rd    = rd_f;
        dec_c.rs1   = rs1_f;
        dec_c.rs2   = rs2_f;
        dec_c.a_sel = A_RS1;
        dec_c.b_sel = B_RS2;
        writes_rd   = 1'b1;
        case (funct3)
          // SUB is ADD with execute negating b.
          F3_ADD: begin
            dec_c.alu_op = ALU_ADD;
            if (funct7 == F7_ALT)       dec_c.b_neg = 1'b1;
            else if (funct7 != F7_BASE) illegal     = 1'b1;
          end
          F3_SR: begin
            dec_c.shift = 1'b1;
            if (funct7 == F7_BASE)     dec_c.alu_op = ALU_SRL;
            else if (funct7 == F7_ALT) dec_c.alu_op = ALU_SRA;
            else                       illegal      = 1'b1;
          end
          default: begin
            case (funct3)
              F3_SLL:  begin dec_c.alu_op = ALU_SLL; dec_c.shift = 1'b1; end
              F3_SLT:  dec_c.alu_op = ALU_SLT;
              F3_SLTU: dec_c.alu_op = ALU_SLTU;
              F3_XOR:  dec_c.alu_op = ALU_XOR;
              F3_OR:   dec_c.alu_op = ALU_OR;
              default: dec_c.alu_op = ALU_AND;
            endcase
            illegal = (funct7 != F7_BASE);
          end
        endcase
      end

      default: illegal = 1'b1;
    endcase

    // Writes to x0 are architecturally discarded; don't request them.
    dec_c.rd_we = writes_rd & (rd_f != 5'd0);

    // An illegal encoding keeps only its pc so the trap handler can report it.
    if (illegal) begin
      dec_c         = '0;
      dec_c.pc      = pc_i;
      dec_c.illegal = 1'b1;
    end

    dec_o = dec_c;
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode pipeline stage feeding the ALU/execute stage.
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   flush_i         : drop all buffered commands (branch redirect)
//   in_valid_i/in_ready_o, in_instr_i, in_pc_i : fetch handshake
//   out_valid_o/out_ready_i, out_dec_o         : command handshake to execute
// Each instruction is decoded combinationally on entry and registered into
// a 2-entry skid buffer (head + skid). in_ready_o depends only on the
// occupancy register, so there is no combinational path from out_ready_i
// back to the fetch side, while throughput remains one command per cycle.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_W  // only 32 is supported
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] in_instr_i,
  input  logic [XLEN-1:0] in_pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output dec_t            out_dec_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t state_q, state_d;
  dec_t head_q, head_d;
  dec_t skid_q, skid_d;
  dec_t dec_c;

  logic in_xfer;
  logic out_xfer;

  rv32i_decoder u_decoder (
    .instr_i (in_instr_i),
    .pc_i    (in_pc_i),
    .dec_o   (dec_c)
  );

  assign in_ready_o  = (state_q != TWO);
  assign out_valid_o = (state_q != EMPTY);
  assign out_dec_o   = head_q;

  assign in_xfer  = in_valid_i & in_ready_o;
  assign out_xfer = out_valid_o & out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;

    // Flush wins over any transfer; the data registers are simply left
    // stale since out_valid_o masks them.
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            head_d  = dec_c;
            state_d = ONE;
          end
        end
        ONE: begin
          case ({in_xfer, out_xfer})
            2'b11: head_d = dec_c;
            2'b10: begin
              skid_d  = dec_c;
              state_d = TWO;
            end
            2'b01: state_d = EMPTY;
            default: ;
          endcase
        end
        TWO: begin
          // in_ready_o is low here, so only the drain side can move.
          if (out_xfer) begin
            head_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] in_instr_i = '0;
  logic [31:0] in_pc_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  dec_t        out_dec_o;

  int   n_checks = 0;
  int   n_errors = 0;
  dec_t sb[$];
  dec_t exp_cur = '0;
  logic prev_stall = 1'b0;
  dec_t prev_dec = '0;

  // {b_neg, shift, rd_we, mem_rd, mem_wr, branch, jump, illegal}
  localparam logic [7:0] F_NEG = 8'b1000_0000;
  localparam logic [7:0] F_SH  = 8'b0100_0000;
  localparam logic [7:0] F_WE  = 8'b0010_0000;
  localparam logic [7:0] F_MR  = 8'b0001_0000;
  localparam logic [7:0] F_MW  = 8'b0000_1000;
  localparam logic [7:0] F_BR  = 8'b0000_0100;
  localparam logic [7:0] F_J   = 8'b0000_0010;
  localparam logic [7:0] F_ILL = 8'b0000_0001;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_instr_i  (in_instr_i),
    .in_pc_i     (in_pc_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_dec_o   (out_dec_o)
  );

  function automatic dec_t mk(input logic [31:0] pc, input logic [31:0] imm,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input alu_op_t op,
                              input a_sel_t a, input b_sel_t b,
                              input logic [7:0] flags, input logic [2:0] f3);
    dec_t d;
    d        = '0;
    d.pc     = pc;
    d.imm    = imm;
    d.rs1    = rs1;
    d.rs2    = rs2;
    d.rd     = rd;
    d.alu_op = op;
    d.a_sel  = a;
    d.b_sel  = b;
    d.funct3 = f3;
    {d.b_neg, d.shift, d.rd_we, d.mem_rd, d.mem_wr, d.branch, d.jump, d.illegal} = flags;
    return d;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on accepted input, pop/compare on accepted output.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst_n || flush_i) begin
        sb.delete();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && out_valid_o)
          chk("hold_stable", 128'(out_dec_o), 128'(prev_dec));
        if (out_valid_o && out_ready_i) begin
          chk("sb_nonempty", 128'(sb.size() != 0), 128'(1));
          if (sb.size() != 0) chk("sb_cmd", 128'(out_dec_o), 128'(sb.pop_front()));
        end
        if (in_valid_i && in_ready_o) sb.push_back(exp_cur);
        prev_stall = out_valid_o && !out_ready_i;
        prev_dec   = out_dec_o;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $fatal(1, "FAIL watchdog: simulation did not finish");
  end

  // All tasks start and end at posedge+1.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input dec_t exp);
    logic acc;
    acc        = 1'b0;
    in_valid_i = 1'b1;
    in_instr_i = instr;
    in_pc_i    = pc;
    exp_cur    = exp;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready_o;
      @(posedge clk);
      #1;
    end
    chk("send_accepted", 128'(acc), 128'(1));
    in_valid_i = 1'b0;
  endtask

  task automatic drain();
    out_ready_i = 1'b1;
    for (int k = 0; k < 50 && (sb.size() != 0 || out_valid_o); k++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_sb_empty", 128'(sb.size()), 128'(0));
    chk("drain_out_valid", 128'(out_valid_o), 128'(0));
  endtask

  logic [31:0] s_instr[6];
  dec_t        s_exp[6];
  dec_t        e_addi, e_sub, e_srai, e_y;

  initial begin : stim
    int   idx;
    int   cyc;
    logic acc;
    logic dropped;

    e_addi = mk(32'h100, 32'd5, 5'd0, 5'd0, 5'd1, ALU_ADD, A_RS1, B_IMM, F_WE, 3'd0);
    e_sub  = mk(32'h104, 32'd0, 5'd1, 5'd2, 5'd3, ALU_ADD, A_RS1, B_RS2, F_NEG | F_WE, 3'd0);
    e_srai = mk(32'h108, 32'd3, 5'd6, 5'd0, 5'd5, ALU_SRA, A_RS1, B_IMM, F_SH | F_WE, 3'd0);

    s_instr[0] = 32'h123453B7;  // lui   x7, 0x12345
    s_exp[0]   = mk(32'h200, 32'h12345000, 5'd0, 5'd0, 5'd7, ALU_ADD, A_ZERO, B_IMM, F_WE, 3'd0);
    s_instr[1] = 32'h00001417;  // auipc x8, 1
    s_exp[1]   = mk(32'h204, 32'h00001000, 5'd0, 5'd0, 5'd8, ALU_ADD, A_PC, B_IMM, F_WE, 3'd0);
    s_instr[2] = 32'hFFC12483;  // lw    x9, -4(x2)
    s_exp[2]   = mk(32'h208, 32'hFFFFFFFC, 5'd2, 5'd0, 5'd9, ALU_ADD, A_RS1, B_IMM, F_WE | F_MR, 3'd2);
    s_instr[3] = 32'h00912423;  // sw    x9, 8(x2)
    s_exp[3]   = mk(32'h20C, 32'd8, 5'd2, 5'd9, 5'd0, ALU_ADD, A_RS1, B_IMM, F_MW, 3'd2);
    s_instr[4] = 32'hFE208CE3;  // beq   x1, x2, -8
    s_exp[4]   = mk(32'h210, 32'hFFFFFFF8, 5'd1, 5'd2, 5'd0, ALU_NOP, A_RS1, B_RS2, F_BR, 3'd0);
    s_instr[5] = 32'h010000EF;  // jal   x1, 16
    s_exp[5]   = mk(32'h214, 32'd16, 5'd0, 5'd0, 5'd1, ALU_ADD, A_PC, B_IMM, F_WE | F_J, 3'd0);

    // Reset state
    #2;
    chk("rst_out_valid", 128'(out_valid_o), 128'(0));
    chk("rst_in_ready", 128'(in_ready_o), 128'(1));
    chk("rst_out_dec", 128'(out_dec_o), 128'(0));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADDI with latency 1
    out_ready_i = 1'b1;
    send(32'h00500093, 32'h100, e_addi);
    @(negedge clk);
    chk("addi_latency_valid", 128'(out_valid_o), 128'(1));
    chk("addi_cmd", 128'(out_dec_o), 128'(e_addi));
    @(posedge clk); #1;
    drain();

    // SUB then SRAI back-to-back
    send(32'h402081B3, 32'h104, e_sub);
    send(32'h40335293, 32'h108, e_srai);
    @(negedge clk);
    chk("b2b_second_valid", 128'(out_valid_o), 128'(1));
    chk("b2b_second_cmd", 128'(out_dec_o), 128'(e_srai));
    @(posedge clk); #1;
    drain();

    // Stream of 6 with out_ready low in cycles 2..4
    idx = 0; cyc = 0; dropped = 1'b0;
    while (idx < 6 && cyc < 60) begin
      out_ready_i = !(cyc >= 2 && cyc <= 4);
      in_valid_i  = 1'b1;
      in_instr_i  = s_instr[idx];
      in_pc_i     = 32'h200 + 32'(idx * 4);
      exp_cur     = s_exp[idx];
      @(negedge clk);
      acc = in_ready_o;
      if (!in_ready_o) dropped = 1'b1;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    in_valid_i = 1'b0;
    chk("stream_all_accepted", 128'(idx), 128'(6));
    chk("stream_in_ready_dropped", 128'(dropped), 128'(1));
    drain();

    // Misc decodes including illegal encodings
    out_ready_i = 1'b1;
    send(32'h00008067, 32'h300, mk(32'h300, 32'd0, 5'd1, 5'd0, 5'd0, ALU_ADD, A_RS1, B_IMM, F_J, 3'd0));
    send(32'h0062C233, 32'h304, mk(32'h304, 32'd0, 5'd5, 5'd6, 5'd4, ALU_XOR, A_RS1, B_RS2, F_WE, 3'd0));
    send(32'h00000000, 32'h308, mk(32'h308, 32'd0, 5'd0, 5'd0, 5'd0, ALU_NOP, A_RS1, B_RS2, F_ILL, 3'd0));
    send(32'hFE000033, 32'h30C, mk(32'h30C, 32'd0, 5'd0, 5'd0, 5'd0, ALU_NOP, A_RS1, B_RS2, F_ILL, 3'd0));
    send(32'h00003003, 32'h310, mk(32'h310, 32'd0, 5'd0, 5'd0, 5'd0, ALU_NOP, A_RS1, B_RS2, F_ILL, 3'd0));
    send(32'hFFF13093, 32'h314, mk(32'h314, 32'hFFFFFFFF, 5'd2, 5'd0, 5'd1, ALU_SLTU, A_RS1, B_IMM, F_WE, 3'd0));
    drain();

    // Flush while TWO with a valid input offered
    out_ready_i = 1'b0;
    send(32'h402081B3, 32'h104, e_sub);
    send(32'h40335293, 32'h108, e_srai);
    chk("two_in_ready_low", 128'(in_ready_o), 128'(0));
    in_valid_i = 1'b1;
    in_instr_i = 32'h00500093;
    in_pc_i    = 32'h100;
    exp_cur    = e_addi;
    flush_i    = 1'b1;
    @(posedge clk); #1;
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    chk("flush2_out_valid", 128'(out_valid_o), 128'(0));
    chk("flush2_in_ready", 128'(in_ready_o), 128'(1));
    out_ready_i = 1'b1;
    e_y = mk(32'h400, 32'd5, 5'd0, 5'd0, 5'd1, ALU_ADD, A_RS1, B_IMM, F_WE, 3'd0);
    send(32'h00500093, 32'h400, e_y);
    @(negedge clk);
    chk("flush2_first_cmd", 128'(out_dec_o), 128'(e_y));
    @(posedge clk); #1;
    drain();

    // Flush while ONE: the offered input is accepted by the handshake but discarded
    out_ready_i = 1'b0;
    send(32'h402081B3, 32'h104, e_sub);
    in_valid_i = 1'b1;
    in_instr_i = 32'h40335293;
    in_pc_i    = 32'h108;
    exp_cur    = e_srai;
    flush_i    = 1'b1;
    @(posedge clk); #1;
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    chk("flush1_out_valid", 128'(out_valid_o), 128'(0));
    out_ready_i = 1'b1;
    e_y = mk(32'h404, 32'hFFFFFFFF, 5'd2, 5'd0, 5'd1, ALU_SLTU, A_RS1, B_IMM, F_WE, 3'd0);
    send(32'hFFF13093, 32'h404, e_y);
    @(negedge clk);
    chk("flush1_first_cmd", 128'(out_dec_o), 128'(e_y));
    @(posedge clk); #1;
    drain();

    // Asynchronous reset while TWO
    out_ready_i = 1'b0;
    send(32'h402081B3, 32'h104, e_sub);
    send(32'h40335293, 32'h108, e_srai);
    chk("pre_rst_out_valid", 128'(out_valid_o), 128'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 128'(out_valid_o), 128'(0));
    chk("async_rst_in_ready", 128'(in_ready_o), 128'(1));
    chk("async_rst_out_dec", 128'(out_dec_o), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", 128'(out_valid_o), 128'(0));
    chk("post_rst_in_ready", 128'(in_ready_o), 128'(1));
    @(posedge clk); #1;
    out_ready_i = 1'b1;
    send(32'h00500093, 32'h100, e_addi);
    @(negedge clk);
    chk("post_rst_cmd", 128'(out_dec_o), 128'(e_addi));
    @(posedge clk); #1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
RV32I decode pipeline stage that produces the command stream consumed by the ALU.
- Accepts fetched instructions (instr + pc) over a valid/ready handshake.
- Decodes each into a packed command: alu_op_t, operand selects, immediate, register indices, memory and branch controls.
- Presents commands to the execute stage through a 2-entry registered skid buffer, giving 1-cycle latency at full throughput.

Parameters:
XLEN, 32, datapath width of pc, immediate and instruction (only 32 supported).

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
flush_i  input  1  drop all buffered commands (branch redirect)
in_valid_i  input  1  fetch presents an instruction
in_ready_o  input-side output  1  stage can accept; registered, not combinational from out_ready_i
in_instr_i  input  XLEN  raw instruction
in_pc_i  input  XLEN  instruction address
out_valid_o  output  1  command valid to execute
out_ready_i  input  1  execute accepts command
out_dec_o  output  dec_t  decoded command (package struct)

Behaviour:
- Reset (async assert, sync release): buffer EMPTY, out_valid_o=0, in_ready_o=1, out_dec_o=all-zero (alu_op=NOP).
- Transfer rules:
  - Input transfer when in_valid_i & in_ready_o.
  - Output transfer when out_valid_o & out_ready_i.
  - out_dec_o is stable while out_valid_o=1 and out_ready_i=0.
- Buffer FSM, occupancy states EMPTY/ONE/TWO:
  - EMPTY: input transfer -> ONE; data visible the next cycle (latency 1).
  - ONE: input and output in the same cycle -> ONE with the new data. Input only -> TWO (second entry held in skid). Output only -> EMPTY.
  - TWO: in_ready_o=0. Output transfer -> ONE, skid entry promoted to the head.
- Ordering is strict FIFO. No command is dropped or duplicated under any ready pattern.
- Flush:
  - flush_i=1 -> EMPTY next cycle, out_valid_o=0.
  - An input offered in the flush cycle is discarded.
  - Flush has priority over simultaneous input and output transfers.
- Decode is combinational at the input and is registered into the buffer.
- ALU op mapping:
  - ADD/ADDI, loads, stores, LUI (a=ZERO), AUIPC/JAL (a=PC), JALR -> ADD.
  - SUB -> ADD with b_neg=1; execute feeds two's complement of b.
  - AND/OR/XOR(+I), SLT/SLTU(+I), SLL/SRL/SRA(+I) map one-to-one.
  - Branches -> NOP with branch=1 and funct3 carried; execute compares.
- Immediates:
  - I/S/B/U/J formats sign-extended to XLEN. U format = instr[31:12]<<12.
  - Shift-immediate imm = zero-extended shamt[4:0].
  - shift=1 on all shifts; execute masks b to 5 bits.
- Control outputs:
  - rd_we=1 only for result-writing ops with rd!=0.
  - mem_rd/mem_wr for LOAD/STORE.
  - jump for JAL/JALR.
- Illegal encodings:
  - Covers unknown opcode, bad funct7 on OP or shift-imm, and bad funct3 on load/store/branch.
  - Result: illegal=1, alu_op=NOP, rd_we=mem_rd=mem_wr=branch=jump=0. pc still carried.
- Reset mid-operation: buffered commands are lost; out_valid_o falls asynchronously with rst_n.

Decomposition:
- Package riscv_pkg holds:
  - alu_op_t, moved there from the ALU file and shared by both blocks.
  - RV32I opcode/funct3/funct7 localparams.
  - a_sel_t {RS1, PC, ZERO} and b_sel_t {RS2, IMM}.
  - struct dec_t {pc, imm, rs1, rs2, rd, alu_op, a_sel, b_sel, b_neg, shift, rd_we, mem_rd, mem_wr, funct3, branch, jump, illegal}.
- Sub-module rv32i_decoder: purely combinational instr -> dec_t.
- decode_stage wraps rv32i_decoder with the skid buffer.

Test Plan:
- ADDI x1,x0,5 (0x00500093), pc=0x100, out_ready=1 -> next cycle out_valid=1, alu_op=ADD, rd=1, rs1=0, imm=5, b_sel=IMM, rd_we=1, pc=0x100.
- SUB x3,x1,x2 (0x402081B3) then SRAI x5,x6,3 (0x40335293) back-to-back -> first: ADD, b_neg=1, b_sel=RS2. Second: SRA, imm=3, shift=1. One command per cycle.
- Stream of 6 instrs with out_ready_i low for cycles 2-4 -> in_ready_o drops after occupancy reaches TWO; all 6 appear in order, no loss or duplication.
- 0x00000000 and 0xFE000033 (bad funct7) -> illegal=1, alu_op=NOP, rd_we=0.
- Occupancy TWO plus valid input while flush_i=1 -> next cycle out_valid=0, in_ready=1; the following accepted instr is the first output.
- rst_n low asynchronously while in state TWO -> out_valid_o=0 immediately; after release, in_ready_o=1 and the buffer is empty.
